// File: rtl/tw_rom_sched.sv
// tw_rom_sched: sequencer for one radix-16 twiddle ROM instance.
// Optionally streams two half-rows of horizontal twiddles into the ROM stage-0
// buffer, then sweeps STAGE_NUM stages of BEATS enabled cycles each, separated
// by GAP_CYCLES disabled cycles.
module tw_rom_sched #(
   parameter int unsigned SC_WIDTH   = 3,
   parameter int unsigned S_WIDTH    = 4,
   parameter int unsigned STAGE_NUM  = 3,
   parameter int unsigned BEATS      = 256,
   parameter int unsigned GAP_CYCLES = 2,
   parameter int unsigned LOAD_ROWS  = 4
) (
   input  logic                CLK,
   input  logic                rst,
   input  logic                start,
   input  logic                load_en,
   input  logic                abort,
   input  logic                hd_valid,
   output logic                hd_ready,
   output logic [SC_WIDTH-1:0] stage_counter,
   output logic                CEN,
   output logic [S_WIDTH-1:0]  state,
   output logic [1:0]          ROM4_w,
   output logic                tw_valid,
   output logic                busy,
   output logic                done
);

   // One shared counter serves run beats, load beats and gap cycles.
   localparam int unsigned BEAT_W = ($clog2(BEATS) < 3) ? 3 : $clog2(BEATS);
   localparam int unsigned LOAD_W = $clog2(LOAD_ROWS + 1);
   localparam int unsigned GAP_W  = $clog2(GAP_CYCLES + 1);
   localparam int unsigned CW0    = (LOAD_W > BEAT_W) ? LOAD_W : BEAT_W;
   localparam int unsigned CW     = (GAP_W > CW0) ? GAP_W : CW0;

   // Phase codes seen by the ROM counters.
   localparam logic [S_WIDTH-1:0] ST_IDLE     = S_WIDTH'(0);
   localparam logic [S_WIDTH-1:0] ST_LOAD     = S_WIDTH'(2);
   localparam logic [S_WIDTH-1:0] ST_RUN_EVEN = S_WIDTH'(4);
   localparam logic [S_WIDTH-1:0] ST_RUN_ODD  = S_WIDTH'(6);
   localparam logic [S_WIDTH-1:0] ST_GAP      = S_WIDTH'(8);
   localparam logic [S_WIDTH-1:0] ST_DONE     = S_WIDTH'(9);

   localparam logic [CW-1:0]       LAST_BEAT  = CW'(BEATS - 1);
   localparam logic [CW-1:0]       LAST_ROW   = CW'(LOAD_ROWS - 1);
   localparam logic [CW-1:0]       LAST_GAP   = CW'(GAP_CYCLES - 1);
   localparam logic [SC_WIDTH-1:0] LAST_STAGE = SC_WIDTH'(STAGE_NUM - 1);

   typedef enum logic [2:0] {
      P_IDLE,
      P_LOAD_HI,
      P_LTURN,
      P_LOAD_LO,
      P_RUN,
      P_GAP,
      P_DONE
   } phase_t;

   phase_t               phase;
   logic [CW-1:0]        cnt;
   logic                 xfer;
   logic [SC_WIDTH-1:0]  next_stage;

   assign xfer       = hd_valid & hd_ready;
   assign next_stage = stage_counter + SC_WIDTH'(1);

   // Write strobe follows the live handshake so the ROM row index stays in step.
   always_comb begin
      ROM4_w = 2'd0;
      if (xfer && phase == P_LOAD_HI) ROM4_w = 2'd1;
      if (xfer && phase == P_LOAD_LO) ROM4_w = 2'd2;
   end

   // Phase sequencing with registered ROM controls.
   always_ff @(posedge CLK) begin
      if (rst) begin
         phase         <= P_IDLE;
         cnt           <= '0;
         stage_counter <= '1;
         CEN           <= 1'b1;
         state         <= ST_IDLE;
         hd_ready      <= 1'b0;
         tw_valid      <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
      end else begin
         tw_valid <= ~CEN;
         done     <= 1'b0;
         if (abort) begin
            phase         <= P_IDLE;
            cnt           <= '0;
            stage_counter <= '1;
            CEN           <= 1'b1;
            state         <= ST_IDLE;
            hd_ready      <= 1'b0;
            busy          <= 1'b0;
         end else begin
            case (phase)
               P_IDLE: begin
                  if (start) begin
                     busy <= 1'b1;
                     cnt  <= '0;
                     if (load_en) begin
                        phase    <= P_LOAD_HI;
                        state    <= ST_LOAD;
                        hd_ready <= 1'b1;
                     end else begin
                        phase         <= P_RUN;
                        state         <= ST_RUN_EVEN;
                        stage_counter <= '0;
                        CEN           <= 1'b0;
                     end
                  end
               end
               P_LOAD_HI: begin
                  if (!hd_valid) begin
                     cnt <= '0;
                  end else if (cnt == LAST_ROW) begin
                     phase    <= P_LTURN;
                     cnt      <= '0;
                     hd_ready <= 1'b0;
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
               P_LTURN: begin
                  phase    <= P_LOAD_LO;
                  cnt      <= '0;
                  hd_ready <= 1'b1;
               end
               P_LOAD_LO: begin
                  if (!hd_valid) begin
                     cnt <= '0;
                  end else if (cnt == LAST_ROW) begin
                     phase         <= P_RUN;
                     cnt           <= '0;
                     hd_ready      <= 1'b0;
                     state         <= ST_RUN_EVEN;
                     stage_counter <= '0;
                     CEN           <= 1'b0;
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
               P_RUN: begin
                  if (cnt == LAST_BEAT) begin
                     cnt <= '0;
                     CEN <= 1'b1;
                     if (stage_counter == LAST_STAGE) begin
                        phase         <= P_DONE;
                        state         <= ST_DONE;
                        stage_counter <= '1;
                        done          <= 1'b1;
                     end else begin
                        phase <= P_GAP;
                        state <= ST_GAP;
                     end
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
               P_GAP: begin
                  if (cnt == LAST_GAP) begin
                     phase         <= P_RUN;
                     cnt           <= '0;
                     CEN           <= 1'b0;
                     stage_counter <= next_stage;
                     state         <= next_stage[0] ? ST_RUN_ODD : ST_RUN_EVEN;
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
               P_DONE: begin
                  phase         <= P_IDLE;
                  cnt           <= '0;
                  stage_counter <= '1;
                  CEN           <= 1'b1;
                  state         <= ST_IDLE;
                  hd_ready      <= 1'b0;
                  busy          <= 1'b0;
               end
               default: begin
                  phase <= P_IDLE;
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_tw_rom_sched.sv
// Bench for tw_rom_sched: per-cycle timeline model derived from stage/load arithmetic.
module tb_tw_rom_sched;

   localparam int B  = 16;
   localparam int G  = 2;
   localparam int S  = 3;
   localparam int LR = 4;
   localparam int NC = 160;

   logic       CLK, rst, start, load_en, abort, hd_valid;
   logic       hd_ready, CEN, tw_valid, busy, done;
   logic [2:0] stage_counter;
   logic [3:0] state;
   logic [1:0] ROM4_w;

   typedef struct packed {
      logic       cen;
      logic [2:0] sc;
      logic [3:0] st;
      logic       rdy;
      logic [1:0] w;
      logic       twv;
      logic       bsy;
      logic       dn;
   } snap_t;

   localparam snap_t IDLE_SNAP = '{cen:1'b1, sc:3'd7, st:4'd0, rdy:1'b0, w:2'd0,
                                   twv:1'b0, bsy:1'b0, dn:1'b0};

   snap_t obs  [NC];
   snap_t expv [NC];
   bit    hv   [NC];
   int    vectors = 0;
   int    miscompares = 0;

   tw_rom_sched #(
      .SC_WIDTH(3), .S_WIDTH(4), .STAGE_NUM(S), .BEATS(B), .GAP_CYCLES(G), .LOAD_ROWS(LR)
   ) dut (
      .CLK(CLK), .rst(rst), .start(start), .load_en(load_en), .abort(abort),
      .hd_valid(hd_valid), .hd_ready(hd_ready), .stage_counter(stage_counter),
      .CEN(CEN), .state(state), .ROM4_w(ROM4_w), .tw_valid(tw_valid),
      .busy(busy), .done(done)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Cycle on which LR consecutive valid beats complete, scanning from 'from'.
   function automatic int row_end(input int from);
      int n = 0;
      for (int c = from; c < NC; c++) begin
         if (hv[c]) begin
            n++;
            if (n == LR) return c;
         end else begin
            n = 0;
         end
      end
      return NC;
   endfunction

   // Drives one job (start in relative cycle 0), records outputs, builds the expected timeline.
   task automatic play_job(input bit ld, input int ab, input int rs, input bit rand_xs,
                           output int last);
      int    h, l, r0, dc, cut, xs, k, off, hi;
      snap_t e;
      start = 0; load_en = 0; abort = 0; rst = 0; hd_valid = 0;
      repeat (2) @(posedge CLK);
      #1;
      h = -10; l = -10;
      if (ld) begin
         h  = row_end(1);
         l  = row_end(h + 2);
         r0 = l + 1;
      end else begin
         r0 = 1;
      end
      dc   = r0 + S * B + (S - 1) * G;
      cut  = (ab >= 0) ? ab : rs;
      last = (cut >= 0) ? cut + 3 : dc + 3;
      if (last > NC - 1) last = NC - 1;
      xs = -1;
      if (rand_xs) begin
         hi = (cut >= 0 && cut < dc) ? cut : dc;
         if (hi >= 1) xs = int'($urandom_range(hi, 1));
      end
      for (int c = 0; c <= last; c++) begin
         e = IDLE_SNAP;
         if (c >= 1 && c <= dc) e.bsy = 1'b1;
         if (ld && c >= 1 && c <= h) begin
            e.st = 4'd2; e.rdy = 1'b1; e.w = hv[c] ? 2'd1 : 2'd0;
         end
         if (ld && c == h + 1) e.st = 4'd2;
         if (ld && c >= h + 2 && c <= l) begin
            e.st = 4'd2; e.rdy = 1'b1; e.w = hv[c] ? 2'd2 : 2'd0;
         end
         if (c >= r0 && c < dc) begin
            k    = (c - r0) / (B + G);
            off  = (c - r0) % (B + G);
            e.sc = 3'(k);
            if (off < B) begin
               e.cen = 1'b0;
               e.st  = (k % 2 == 1) ? 4'd6 : 4'd4;
            end else begin
               e.st = 4'd8;
            end
         end
         if (c == dc) begin
            e.st = 4'd9; e.dn = 1'b1;
         end
         if (cut >= 0 && c > cut) e = IDLE_SNAP;
         if (c == 0) e.twv = 1'b0;
         else if (rs >= 0 && c == rs + 1) e.twv = 1'b0;
         else e.twv = ~expv[c-1].cen;
         expv[c] = e;
      end
      for (int c = 0; c <= last; c++) begin
         start    = (c == 0) || (c == xs);
         load_en  = (c == 0) ? ld : 1'($urandom_range(1));
         abort    = (c == ab);
         rst      = (c == rs);
         hd_valid = hv[c];
         #1;
         obs[c] = {CEN, stage_counter, state, hd_ready, ROM4_w, tw_valid, busy, done};
         @(posedge CLK);
         #1;
      end
      start = 0; load_en = 0; abort = 0; rst = 0; hd_valid = 0;
   endtask

   task automatic test_reset;
      snap_t o;
      start = 0; load_en = 0; abort = 0; hd_valid = 1; rst = 1;
      for (int i = 0; i < 2; i++) begin
         @(posedge CLK);
         #2;
         o = {CEN, stage_counter, state, hd_ready, ROM4_w, tw_valid, busy, done};
         vectors++;
         if (o !== IDLE_SNAP) begin
            miscompares++;
            $display("FAIL reset cycle %0d: got %h exp %h", i, o, IDLE_SNAP);
         end
      end
      rst = 0; hd_valid = 0;
      @(posedge CLK);
      #1;
   endtask

   task automatic test_run_only;
      int last;
      for (int i = 0; i < NC; i++) hv[i] = 1'($urandom_range(1));
      play_job(1'b0, -1, -1, 1'b0, last);
      for (int c = 0; c <= last; c++) begin
         vectors++;
         if (obs[c] !== expv[c]) begin
            miscompares++;
            $display("FAIL run_only cycle %0d: got %h exp %h", c, obs[c], expv[c]);
         end
      end
      vectors++;
      if (obs[53].dn !== 1'b1 || obs[52].dn !== 1'b0) begin
         miscompares++;
         $display("FAIL run_only_done53: got %b%b exp 01", obs[52].dn, obs[53].dn);
      end
      vectors++;
      if (obs[54].bsy !== 1'b0 || obs[53].bsy !== 1'b1) begin
         miscompares++;
         $display("FAIL run_only_busy54: got %b%b exp 10", obs[53].bsy, obs[54].bsy);
      end
      vectors++;
      if (obs[16].cen !== 1'b0 || obs[17].cen !== 1'b1 || obs[19].cen !== 1'b0) begin
         miscompares++;
         $display("FAIL run_only_cen_edges: got %b%b%b exp 010", obs[16].cen, obs[17].cen, obs[19].cen);
      end
      vectors++;
      if (obs[20].st !== 4'd6 || obs[37].st !== 4'd4 || obs[37].sc !== 3'd2) begin
         miscompares++;
         $display("FAIL run_only_stage2: got st %0d/%0d sc %0d exp 6/4 sc 2", obs[20].st, obs[37].st, obs[37].sc);
      end
      vectors++;
      if (obs[53].twv !== 1'b1 || obs[54].twv !== 1'b0) begin
         miscompares++;
         $display("FAIL run_only_twv_tail: got %b%b exp 10", obs[53].twv, obs[54].twv);
      end
   endtask

   task automatic test_load_full;
      int last;
      for (int i = 0; i < NC; i++) hv[i] = 1'b1;
      play_job(1'b1, -1, -1, 1'b0, last);
      for (int c = 0; c <= last; c++) begin
         vectors++;
         if (obs[c] !== expv[c]) begin
            miscompares++;
            $display("FAIL load_full cycle %0d: got %h exp %h", c, obs[c], expv[c]);
         end
      end
      vectors++;
      if (obs[1].w !== 2'd1 || obs[4].w !== 2'd1 || obs[5].w !== 2'd0 || obs[6].w !== 2'd2 || obs[9].w !== 2'd2) begin
         miscompares++;
         $display("FAIL load_full_w: got %0d %0d %0d %0d %0d exp 1 1 0 2 2",
                  obs[1].w, obs[4].w, obs[5].w, obs[6].w, obs[9].w);
      end
      vectors++;
      if (obs[10].cen !== 1'b0 || obs[9].cen !== 1'b1 || obs[10].rdy !== 1'b0) begin
         miscompares++;
         $display("FAIL load_full_run10: got cen %b%b rdy %b exp 10 rdy 0", obs[9].cen, obs[10].cen, obs[10].rdy);
      end
   endtask

   task automatic test_row_restart;
      int last;
      for (int i = 0; i < NC; i++) hv[i] = 1'b1;
      hv[3] = 1'b0;
      play_job(1'b1, -1, -1, 1'b0, last);
      for (int c = 0; c <= last; c++) begin
         vectors++;
         if (obs[c] !== expv[c]) begin
            miscompares++;
            $display("FAIL row_restart cycle %0d: got %h exp %h", c, obs[c], expv[c]);
         end
      end
      vectors++;
      if (obs[3].w !== 2'd0 || obs[7].w !== 2'd1 || obs[8].w !== 2'd0 || obs[8].rdy !== 1'b0 || obs[9].w !== 2'd2) begin
         miscompares++;
         $display("FAIL row_restart_lturn8: got w %0d %0d %0d %0d rdy8 %b exp 0 1 0 2 rdy8 0",
                  obs[3].w, obs[7].w, obs[8].w, obs[9].w, obs[8].rdy);
      end
   endtask

   task automatic test_abort;
      int last;
      for (int i = 0; i < NC; i++) hv[i] = 1'($urandom_range(1));
      play_job(1'b0, 20, -1, 1'b0, last);
      for (int c = 0; c <= last; c++) begin
         vectors++;
         if (obs[c] !== expv[c]) begin
            miscompares++;
            $display("FAIL abort cycle %0d: got %h exp %h", c, obs[c], expv[c]);
         end
      end
      vectors++;
      if (obs[21].cen !== 1'b1 || obs[21].sc !== 3'd7 || obs[21].bsy !== 1'b0 || obs[21].twv !== 1'b1) begin
         miscompares++;
         $display("FAIL abort_c21: got cen %b sc %0d busy %b twv %b exp 1 7 0 1",
                  obs[21].cen, obs[21].sc, obs[21].bsy, obs[21].twv);
      end
      vectors++;
      if (obs[22].twv !== 1'b0 || obs[21].dn !== 1'b0 || obs[22].dn !== 1'b0 || obs[23].dn !== 1'b0) begin
         miscompares++;
         $display("FAIL abort_tail: got twv22 %b done %b%b%b exp 0 000", obs[22].twv, obs[21].dn, obs[22].dn, obs[23].dn);
      end
   endtask

   task automatic test_ignored_start;
      int last;
      for (int i = 0; i < NC; i++) hv[i] = 1'($urandom_range(1));
      play_job(1'b0, -1, -1, 1'b1, last);
      for (int c = 0; c <= last; c++) begin
         vectors++;
         if (obs[c] !== expv[c]) begin
            miscompares++;
            $display("FAIL ignored_start cycle %0d: got %h exp %h", c, obs[c], expv[c]);
         end
      end
      vectors++;
      if (obs[53].dn !== 1'b1 || obs[54].bsy !== 1'b0) begin
         miscompares++;
         $display("FAIL ignored_start_end: got done53 %b busy54 %b exp 1 0", obs[53].dn, obs[54].bsy);
      end
   endtask

   task automatic test_reset_mid_load;
      int last;
      for (int i = 0; i < NC; i++) hv[i] = 1'b1;
      play_job(1'b1, -1, 7, 1'b0, last);
      for (int c = 0; c <= last; c++) begin
         vectors++;
         if (obs[c] !== expv[c]) begin
            miscompares++;
            $display("FAIL reset_mid_load cycle %0d: got %h exp %h", c, obs[c], expv[c]);
         end
      end
      vectors++;
      if (obs[8] !== IDLE_SNAP || obs[7].w !== 2'd2) begin
         miscompares++;
         $display("FAIL reset_mid_load_c8: got %h (w7 %0d) exp %h (w7 2)", obs[8], obs[7].w, IDLE_SNAP);
      end
      for (int i = 0; i < NC; i++) hv[i] = 1'($urandom_range(1));
      play_job(1'b0, -1, -1, 1'b0, last);
      for (int c = 0; c <= last; c++) begin
         vectors++;
         if (obs[c] !== expv[c]) begin
            miscompares++;
            $display("FAIL after_reset_job cycle %0d: got %h exp %h", c, obs[c], expv[c]);
         end
      end
   endtask

   task automatic test_abort_start_idle;
      int last;
      for (int i = 0; i < NC; i++) hv[i] = 1'b1;
      play_job(1'b1, 0, -1, 1'b0, last);
      for (int c = 0; c <= last; c++) begin
         vectors++;
         if (obs[c] !== IDLE_SNAP) begin
            miscompares++;
            $display("FAIL abort_start_idle cycle %0d: got %h exp %h", c, obs[c], IDLE_SNAP);
         end
      end
   endtask

   task automatic test_random;
      int last, drop, ab;
      bit ld;
      for (int it = 0; it < 6; it++) begin
         ld   = 1'($urandom_range(1));
         drop = int'($urandom_range(40));
         for (int i = 0; i < NC; i++) hv[i] = (i >= 60) ? 1'b1 : ($urandom_range(99) >= drop);
         ab = ($urandom_range(2) == 0) ? int'($urandom_range(100)) : -1;
         play_job(ld, ab, -1, 1'b1, last);
         for (int c = 0; c <= last; c++) begin
            vectors++;
            if (obs[c] !== expv[c]) begin
               miscompares++;
               $display("FAIL random it%0d ld%0d ab%0d cycle %0d: got %h exp %h",
                        it, ld, ab, c, obs[c], expv[c]);
            end
         end
      end
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; load_en = 1'b0; abort = 1'b0; hd_valid = 1'b0;
      test_reset();
      test_run_only();
      test_load_full();
      test_row_restart();
      test_abort();
      test_ignored_start();
      test_reset_mid_load();
      test_abort_start_idle();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
